// File: rtl/lut_pkg.sv
// lut_pkg: shared types and helpers for the branch/address lookup table.
//   lut_state_t : table controller state (clear sweep or idle)
//   LUT_IDX_W   : default index width
//   LUT_DATA_W  : default stored entry width
//   LUT_MAX_W   : widest supported output width of the extension helper
//   lut_ext()   : sign- or zero-extends an entry of data_w bits to LUT_MAX_W bits
package lut_pkg;

  typedef enum logic {LUT_CLEAR, LUT_IDLE} lut_state_t;

  localparam int LUT_IDX_W  = 4;
  localparam int LUT_DATA_W = 10;
  localparam int LUT_MAX_W  = 64;

  // The entry arrives zero-padded to LUT_MAX_W bits; only its low data_w bits
  // are meaningful. Callers truncate the result to their own output width.
  function automatic logic [LUT_MAX_W-1:0] lut_ext(
    input logic [LUT_MAX_W-1:0] entry,
    input int                   data_w,
    input logic                 sign_ext
  );
    logic [LUT_MAX_W-1:0] low_mask;
    logic [LUT_MAX_W-1:0] sign_bit;
    logic                 fill;
    low_mask = ~({LUT_MAX_W{1'b1}} << data_w);
    sign_bit = {{(LUT_MAX_W-1){1'b0}}, 1'b1} << (data_w - 1);
    fill     = sign_ext & (|(entry & sign_bit));
    return (entry & low_mask) | ({LUT_MAX_W{fill}} & ~low_mask);
  endfunction

endpackage

// File: rtl/lut_mem.sv
// lut_mem: 2**IDX_W x DATA_W storage array, one synchronous write port and
// one asynchronous read port. No reset; contents are established by the
// controller's clear sweep.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_idx  : write index
//   wr_data : write data
//   rd_idx  : read index
//   rd_data : combinational read data at rd_idx
module lut_mem #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**IDX_W];

  // NOTE: the array has no reset so it maps onto plain storage cells; the
  // controller zeroes it with a sweep instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/branch_lut_ctl.sv
// branch_lut_ctl: runtime-programmable branch-target / address lookup table.
// After reset (or an Init request) a hardware sweep zeroes every entry while
// Busy is high; afterwards entries are written through the write port and read
// with one cycle of latency, extended to OUT_W bits.
//   Clk     : clock, rising edge
//   Reset   : asynchronous active-high reset
//   Init    : one-cycle request to re-clear the table (ignored during a sweep)
//   WrEn/WrIdx/WrData : write port (dropped during a sweep or with Init)
//   RdEn/RdIdx        : read request
//   RdData  : registered, extended entry
//   RdValid : RdData refreshed by a read this cycle
//   Busy    : clear sweep in progress
//   WrDrop  : a write was discarded on the previous edge
module branch_lut_ctl
  import lut_pkg::*;
#(
  parameter int IDX_W    = LUT_IDX_W,
  parameter int DATA_W   = LUT_DATA_W,
  parameter int OUT_W    = 10,
  parameter int SIGN_EXT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Init,
  input  logic              WrEn,
  input  logic [IDX_W-1:0]  WrIdx,
  input  logic [DATA_W-1:0] WrData,
  input  logic              RdEn,
  input  logic [IDX_W-1:0]  RdIdx,
  output logic [OUT_W-1:0]  RdData,
  output logic              RdValid,
  output logic              Busy,
  output logic              WrDrop
);

  if (OUT_W < DATA_W) begin : g_bad_out_w
    $error("branch_lut_ctl: OUT_W must be >= DATA_W");
  end
  if (OUT_W > LUT_MAX_W) begin : g_bad_max_w
    $error("branch_lut_ctl: OUT_W exceeds LUT_MAX_W");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  lut_state_t        state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  logic              busy_q, busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic [OUT_W-1:0]  rd_data_q, rd_data_d;
  logic              wr_drop_q, wr_drop_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_accept;
  logic [DATA_W-1:0] rd_src;
  logic [OUT_W-1:0]  rd_ext;

  lut_mem #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (Clk),
    .wr_en   (mem_we),
    .wr_idx  (mem_waddr),
    .wr_data (mem_wdata),
    .rd_idx  (RdIdx),
    .rd_data (mem_rdata)
  );

  // A write is only committed in IDLE without a simultaneous Init; a matching
  // read in the same cycle sees the new data (write-first).
  assign wr_accept = (state_q == LUT_IDLE) && WrEn && !Init;
  assign rd_src    = (wr_accept && (WrIdx == RdIdx)) ? WrData : mem_rdata;
  assign rd_ext    = OUT_W'(lut_ext(LUT_MAX_W'(rd_src), DATA_W, SIGN_EXT != 0));

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_drop_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = WrIdx;
    mem_wdata  = WrData;

    case (state_q)
      LUT_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + IDX_W'(1);  // wraps to 0 after the last entry
        wr_drop_d = WrEn;
        if (clr_idx_q == LAST_IDX) state_d = LUT_IDLE;
      end
      LUT_IDLE: begin
        mem_we    = wr_accept;
        wr_drop_d = WrEn && Init;
        if (RdEn) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_ext;
        end
        if (Init) begin
          state_d   = LUT_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = LUT_CLEAR;
        clr_idx_d = '0;
      end
    endcase

    busy_d = (state_d == LUT_CLEAR);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= LUT_CLEAR;
      clr_idx_q  <= '0;
      busy_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  assign RdData  = rd_data_q;
  assign RdValid = rd_valid_q;
  assign Busy    = busy_q;
  assign WrDrop  = wr_drop_q;

endmodule

// File: tb/tb_branch_lut_ctl.sv
// tb_branch_lut_ctl: drives a sign-extending and a zero-extending instance
// (DATA_W=10, OUT_W=16) with the same stimulus and compares both against a
// behavioural table model after every clock edge.
module tb_branch_lut_ctl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Init;
  logic        WrEn;
  logic [3:0]  WrIdx;
  logic [9:0]  WrData;
  logic        RdEn;
  logic [3:0]  RdIdx;

  logic [15:0] rd_data_s, rd_data_z;
  logic        rd_valid_s, rd_valid_z;
  logic        busy_s, busy_z;
  logic        wr_drop_s, wr_drop_z;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: table contents plus the number of sweep cycles left.
  int          mem_m [16];
  int          sweep_left;
  logic        e_busy, e_valid, e_drop;
  logic [15:0] e_data_s, e_data_z;

  always #5 Clk = ~Clk;

  branch_lut_ctl #(.IDX_W(4), .DATA_W(10), .OUT_W(16), .SIGN_EXT(1)) dut_s (
    .Clk(Clk), .Reset(Reset), .Init(Init), .WrEn(WrEn), .WrIdx(WrIdx),
    .WrData(WrData), .RdEn(RdEn), .RdIdx(RdIdx), .RdData(rd_data_s),
    .RdValid(rd_valid_s), .Busy(busy_s), .WrDrop(wr_drop_s)
  );

  branch_lut_ctl #(.IDX_W(4), .DATA_W(10), .OUT_W(16), .SIGN_EXT(0)) dut_z (
    .Clk(Clk), .Reset(Reset), .Init(Init), .WrEn(WrEn), .WrIdx(WrIdx),
    .WrData(WrData), .RdEn(RdEn), .RdIdx(RdIdx), .RdData(rd_data_z),
    .RdValid(rd_valid_z), .Busy(busy_z), .WrDrop(wr_drop_z)
  );

  // Two's-complement view of a 10-bit value, or the plain unsigned value.
  function automatic logic [15:0] ext_model(input int v, input bit sign);
    int r;
    r = (sign && v >= 512) ? v - 1024 : v;
    return 16'(r);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sweep_left = 16;
    e_busy     = 1'b1;
    e_valid    = 1'b0;
    e_drop     = 1'b0;
    e_data_s   = 16'h0;
    e_data_z   = 16'h0;
  endtask

  // Applies the inputs present at a rising edge to the model.
  task automatic model_edge();
    int v;
    bit wr_ok;
    if (sweep_left > 0) begin
      e_drop  = WrEn;
      e_valid = 1'b0;
      sweep_left--;
      if (sweep_left == 0) foreach (mem_m[i]) mem_m[i] = 0;
    end else begin
      wr_ok   = WrEn && !Init;
      e_drop  = WrEn && Init;
      e_valid = RdEn;
      if (RdEn) begin
        v        = (wr_ok && WrIdx == RdIdx) ? int'(WrData) : mem_m[RdIdx];
        e_data_s = ext_model(v, 1'b1);
        e_data_z = ext_model(v, 1'b0);
      end
      if (wr_ok) mem_m[WrIdx] = int'(WrData);
      if (Init) sweep_left = 16;
    end
    e_busy = (sweep_left > 0);
  endtask

  task automatic compare_all(input string ph);
    check({ph, ".busy_s"},  16'(busy_s),     16'(e_busy));
    check({ph, ".busy_z"},  16'(busy_z),     16'(e_busy));
    check({ph, ".valid_s"}, 16'(rd_valid_s), 16'(e_valid));
    check({ph, ".valid_z"}, 16'(rd_valid_z), 16'(e_valid));
    check({ph, ".drop_s"},  16'(wr_drop_s),  16'(e_drop));
    check({ph, ".drop_z"},  16'(wr_drop_z),  16'(e_drop));
    check({ph, ".data_s"},  rd_data_s,       e_data_s);
    check({ph, ".data_z"},  rd_data_z,       e_data_z);
  endtask

  // One clock edge: update the model, then sample the DUTs 1 time unit later.
  task automatic step(input string ph);
    @(posedge Clk);
    if (Reset) model_reset();
    else       model_edge();
    #1;
    compare_all(ph);
  endtask

  task automatic quiet();
    Init = 1'b0; WrEn = 1'b0; RdEn = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [9:0] data);
    WrEn = 1'b1; WrIdx = idx; WrData = data;
  endtask

  task automatic do_read(input logic [3:0] idx);
    RdEn = 1'b1; RdIdx = idx;
  endtask

  initial begin
    Reset = 1'b1; Init = 1'b0; WrEn = 1'b0; WrIdx = '0; WrData = '0;
    RdEn = 1'b0; RdIdx = '0;
    foreach (mem_m[i]) mem_m[i] = 0;
    model_reset();

    // Reset sweep, with a write on sweep cycle 4 and reads throughout.
    repeat (2) step("reset");
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      quiet();
      do_read(4'(i));
      if (i == 3) do_write(4'd6, 10'h155);
      step("sweep");
      if (i == 3) check("sweep_wr_drop", 16'(wr_drop_s), 16'h1);
      if (i == 14) check("sweep_busy_edge15", 16'(busy_s), 16'h1);
      if (i == 15) check("sweep_busy_edge16", 16'(busy_s), 16'h0);
    end

    // Every entry reads zero after the sweep.
    for (int i = 0; i < 16; i++) begin
      quiet(); do_read(4'(i));
      step("read_zero");
      check("read_zero_value", rd_data_s, 16'h0000);
      check("read_zero_valid", 16'(rd_valid_s), 16'h1);
    end

    // Sign / zero extension of -408.
    quiet(); do_write(4'd5, 10'b1001101000); step("ext_wr");
    quiet(); do_read(4'd5); step("ext_rd");
    check("ext_sign", rd_data_s, 16'hFE68);
    check("ext_zero", rd_data_z, 16'h0268);

    // Write-first bypass on the same index.
    quiet(); do_write(4'd3, 10'd7); step("byp_wr7");
    quiet(); do_write(4'd3, 10'd9); do_read(4'd3); step("byp_rw");
    check("bypass_same_cycle", rd_data_s, 16'd9);
    quiet(); do_read(4'd3); step("byp_rd");
    check("bypass_next_cycle", rd_data_s, 16'd9);

    // Init in IDLE with a same-cycle write (dropped) and read (old data).
    quiet(); do_write(4'd2, 10'd5); step("init_wr5");
    quiet(); Init = 1'b1; do_write(4'd2, 10'h3FF); do_read(4'd2); step("init_req");
    check("init_read_old", rd_data_s, 16'd5);
    check("init_wr_drop", 16'(wr_drop_s), 16'h1);
    for (int i = 0; i < 16; i++) begin
      quiet(); do_read(4'(i)); step("init_sweep");
    end
    check("init_busy_done", 16'(busy_s), 16'h0);
    quiet(); do_read(4'd2); step("init_rd2");
    check("init_idx2_cleared", rd_data_s, 16'h0000);

    // Async reset in the middle of a sweep, with RdData and WrDrop nonzero.
    quiet(); do_write(4'd9, 10'h2A5); step("ar_wr");
    quiet(); do_read(4'd9); step("ar_rd");
    quiet(); Init = 1'b1; step("ar_init");
    for (int i = 0; i < 7; i++) begin
      quiet();
      if (i == 6) do_write(4'd1, 10'h001);
      step("ar_sweep");
    end
    #3 Reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst_data", rd_data_s, 16'h0000);
    quiet();
    repeat (2) step("ar_held");
    Reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      quiet(); do_read(4'(i)); step("ar_resweep");
    end

    // Randomised traffic, biased toward same-index read/write pairs.
    for (int i = 0; i < 400; i++) begin
      Init   = ($urandom_range(0, 59) == 0);
      WrEn   = 1'($urandom_range(0, 1));
      WrIdx  = 4'($urandom_range(0, 15));
      WrData = 10'($urandom_range(0, 1023));
      RdEn   = 1'($urandom_range(0, 1));
      RdIdx  = ($urandom_range(0, 3) == 0) ? WrIdx : 4'($urandom_range(0, 15));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_lut_ctl.md
# branch_lut_ctl

Runtime-programmable branch-target / address lookup table for the 3BC processor, replacing the fixed hard-coded table. It holds `DEPTH = 2**IDX_W` entries of `DATA_W` bits. Entries are cleared by a hardware sweep after reset, loaded by the loader/testbench through a write port, and read with registered, sign- or zero-extended output. It sits between the instruction decoder (read index) and the fetch/PC unit (branch offset) or data-memory address path.

## Interface
- `IDX_W`, default 4: index width; `DEPTH = 2**IDX_W`.
- `DATA_W`, default 10: stored entry width.
- `OUT_W`, default 10: output width. Must satisfy `OUT_W >= DATA_W`, enforced by an elaboration-time assertion.
- `SIGN_EXT`, default 1: 1 means sign-extend entries to `OUT_W`, 0 means zero-extend.
- `Clk`, input, 1: sole clock. All state changes on the rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `Init`, input, 1: one-cycle request to re-clear the whole table.
- `WrEn`, input, 1: write strobe.
- `WrIdx`, input, `IDX_W`: write index.
- `WrData`, input, `DATA_W`: write data.
- `RdEn`, input, 1: read strobe.
- `RdIdx`, input, `IDX_W`: read index.
- `RdData`, output, `OUT_W`: extended entry, registered.
- `RdValid`, output, 1: `RdData` is valid this cycle.
- `Busy`, output, 1: clear sweep in progress.
- `WrDrop`, output, 1: pulses when a write was discarded.

## Operation
- **States:** `CLEAR` and `IDLE`, plus a sweep counter `ClrIdx` (`IDX_W` bits).
- **Reset values:**
  - state = `CLEAR`, `ClrIdx` = 0
  - `Busy` = 1, `RdValid` = 0, `RdData` = 0, `WrDrop` = 0
  - array contents are undefined until the sweep finishes.
- **`CLEAR` state:**
  - Each cycle writes 0 to entry `ClrIdx`, then increments `ClrIdx`.
  - When `ClrIdx == DEPTH-1` is written, the next state is `IDLE` and `ClrIdx` wraps to 0.
  - `RdEn` is ignored: `RdValid` stays 0 and `RdData` holds its value.
  - `WrEn` is discarded and `WrDrop` = 1 the next cycle.
  - `Init` is ignored.
- **`IDLE` state:**
  - `WrEn`: `mem[WrIdx] <= WrData`.
  - `RdEn`: next cycle `RdValid` = 1 and `RdData` = ext(`mem[RdIdx]`).
  - Without `RdEn`: `RdValid` = 0 next cycle and `RdData` holds its value.
- **Read/write same index, same cycle:** write-first. The read returns `WrData`, extended.
- **`Init` in `IDLE`:**
  - Next state is `CLEAR` with `ClrIdx` = 0.
  - A same-cycle `WrEn` is discarded with a `WrDrop` pulse.
  - A same-cycle `RdEn` is still served with the old data.
- **Extension rule:**
  - `SIGN_EXT`=1: replicate `WrData[DATA_W-1]` / `mem[i][DATA_W-1]` into `RdData[OUT_W-1:DATA_W]`.
  - `SIGN_EXT`=0: fill those bits with zeros.
  - `OUT_W == DATA_W`: pass-through.
- **Reset mid-sweep or mid-read:** asynchronously returns to the reset values. The sweep restarts from index 0 after `Reset` deasserts.

## Timing
- **Sweep length:** `DEPTH` cycles. With `Reset` released before edge 1, `Busy` = 1 through edge `DEPTH` and 0 after edge `DEPTH` (default: 16 edges).
- **Read latency:** 1 cycle, `RdEn` at edge N gives `RdValid`/`RdData` after edge N.
- **Reads:** fully pipelined, one per cycle.
- **Write latency:** a write is visible to a read issued in the same cycle (bypass) and in any later cycle.
- **`WrDrop`:** registered, 1 cycle after the dropped write.
- **`Init` to `Busy`:** `Busy` rises 1 cycle after `Init`.
- **Critical path:** no combinational path from any input to any output; all outputs are registered.

## Structure
- **Shared package `lut_pkg`:**
  - `typedef enum logic {LUT_CLEAR, LUT_IDLE} lut_state_t`
  - default constants `LUT_IDX_W` = 4 and `LUT_DATA_W` = 10
  - function `lut_ext` (entry, sign flag) returning the `OUT_W`-wide value.
- **Sub-module `lut_mem`:** parametrised storage with
  - 1 write port
  - 1 asynchronous-read port
  - no reset on the array.
- **Top:** `branch_lut_ctl` holds the state machine, sweep counter, bypass mux, extension and output registers.

## Test plan
1. **Reset sweep:** assert `Reset` mid-run, then release. Required: `Busy` = 1 for exactly 16 edges. Reading every index afterwards returns `RdData` = 0, each with `RdValid` = 1 one cycle after `RdEn`.
2. **Sign extension** (`DATA_W`=10, `OUT_W`=16):
   - `SIGN_EXT`=1: write idx 5 = `10'b1001101000` (-408), then read idx 5. Required: `RdData` = `16'hFE68`.
   - `SIGN_EXT`=0: repeat. Required: `16'h0268`.
3. **Write-first bypass:** idx 3 holds 7. Same cycle: write idx 3 = 9 and read idx 3. Required: `RdData` = 9. A read of idx 3 on the next cycle also returns 9.
4. **Access during sweep:** `WrEn` at cycle 4 of the sweep. Required: `WrDrop` pulses 1 cycle later and the entry reads 0 after the sweep. `RdEn` during the sweep gives `RdValid` = 0.
5. **Init:** `Init` in `IDLE` with idx 2 = 5. Required: `Busy` = 1 for 16 cycles, then idx 2 reads 0. A same-cycle `WrEn` raises `WrDrop`.
6. **Async reset mid-sweep:** assert `Reset` at cycle 8 of the sweep, asynchronously between edges. Required: outputs return to reset values immediately. After release, `Busy` again lasts a full 16 edges.
